// File: rtl/sdram_wr_arbiter_pkg.sv
// Shared SDRAM controller parameters and write-path state encodings.
package sdram_wr_arbiter_pkg;

    localparam int DATA_SIZE = 32;
    localparam int DQM_SIZE  = 4;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_RECOV = 2'd3
    } wr_state_t;

endpackage

// File: rtl/wr_arb_select.sv
// Two-way winner selection; pointer decides ties (tie it low for fixed priority to req0).
module wr_arb_select (
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = pointer;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_wr_arbiter.sv
// Two-host SDRAM write arbiter: grants one host, handshakes the WRITE command, streams one burst.
// Define WR_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise req0 wins ties.
module sdram_wr_arbiter
    import sdram_wr_arbiter_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int dqm_size  = DQM_SIZE,
    parameter int burst_len = BURST_LEN
) (
    input  logic                 clk0,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [data_size-1:0] wdata0,
    input  logic [data_size-1:0] wdata1,
    input  logic [dqm_size-1:0]  wdm0,
    input  logic [dqm_size-1:0]  wdm1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 wr_req,
    input  logic                 wr_ack,
    output logic [data_size-1:0] datain,
    output logic [dqm_size-1:0]  dm,
    output logic                 data_valid,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(burst_len - 1);

    wr_state_t          state;
    logic               owner;
    logic [CNT_W-1:0]   cnt;
    logic               pick;
    logic               pointer;
    logic               owner_req;
    logic [data_size-1:0] owner_data;
    logic [dqm_size-1:0]  owner_dm;
    logic               burst_done;

    assign owner_req  = owner ? req1 : req0;
    assign owner_data = owner ? wdata1 : wdata0;
    assign owner_dm   = owner ? wdm1 : wdm0;
    // cnt tracks the index of the word currently on datain, so the burst ends once the last one is shown
    assign burst_done = (state == ST_DATA) && data_valid && (cnt == LAST);

`ifdef WR_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            pointer <= 1'b0;
        end else if (burst_done) begin
            pointer <= ~owner;
        end
    end
`else
    assign pointer = 1'b0;
`endif

    wr_arb_select u_select (
        .req0    (req0),
        .req1    (req1),
        .pointer (pointer),
        .winner  (pick)
    );

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            wr_req     <= 1'b0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            datain     <= '0;
            dm         <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state  <= ST_CMD;
                        owner  <= pick;
                        gnt0   <= ~pick;
                        gnt1   <= pick;
                        wr_req <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (wr_ack) begin
                        state  <= ST_DATA;
                        wr_req <= 1'b0;
                        cnt    <= '0;
                    end else if (!owner_req) begin
                        state  <= ST_IDLE;
                        gnt0   <= 1'b0;
                        gnt1   <= 1'b0;
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (burst_done) begin
                        state      <= ST_RECOV;
                        gnt0       <= 1'b0;
                        gnt1       <= 1'b0;
                        ack0       <= 1'b0;
                        ack1       <= 1'b0;
                        data_valid <= 1'b0;
                        datain     <= '0;
                        dm         <= '1;
                        cnt        <= '0;
                    end else begin
                        data_valid <= 1'b1;
                        datain     <= owner_data;
                        dm         <= owner_dm;
                        ack0       <= ~owner;
                        ack1       <= owner;
                        if (data_valid) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RECOV: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// Scoreboard bench for sdram_wr_arbiter: the host model feeds words on ack, a monitor checks every data beat.
module tb_sdram_wr_arbiter;

    localparam int BL = 4;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic [3:0]  m;
    } beat_t;

    logic        clk0 = 1'b0;
    logic        reset;
    logic        req0, req1, wr_ack;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  wdm0, wdm1;
    logic        gnt0, gnt1, ack0, ack1, wr_req, data_valid, busy;
    logic [31:0] datain;
    logic [3:0]  dm;

    int errors = 0;
    int checks = 0;

    beat_t sb[$];

    logic [31:0] w0[8], w1[8];
    logic [3:0]  m0[8], m1[8];
    int ack_cnt0 = 0, ack_cnt1 = 0;
    int base0 = 0, base1 = 0;
    bit last_win = 1'b1;

    always #5 clk0 = ~clk0;

    sdram_wr_arbiter #(.data_size(32), .dqm_size(4), .burst_len(BL)) dut (
        .clk0       (clk0),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .wdm0       (wdm0),
        .wdm1       (wdm1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .ack0       (ack0),
        .ack1       (ack1),
        .wr_req     (wr_req),
        .wr_ack     (wr_ack),
        .datain     (datain),
        .dm         (dm),
        .data_valid (data_valid),
        .busy       (busy)
    );

    // Host model: present the next word after each ack.
    assign wdata0 = w0[3'(ack_cnt0 - base0)];
    assign wdm0   = m0[3'(ack_cnt0 - base0)];
    assign wdata1 = w1[3'(ack_cnt1 - base1)];
    assign wdm1   = m1[3'(ack_cnt1 - base1)];

    always @(negedge clk0) begin
        if (ack0) ack_cnt0 <= ack_cnt0 + 1;
        if (ack1) ack_cnt1 <= ack_cnt1 + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid beat must match the head of the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(posedge clk0);
            #1;
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got datain %0h expected no beat", datain);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", datain, e.d);
                    chk("beat_dm", dm, e.m);
                    chk("beat_ack", {ack1, ack0}, e.w ? 2'b10 : 2'b01);
                    chk("beat_gnt", {gnt1, gnt0}, e.w ? 2'b10 : 2'b01);
                end
            end
        end
    end

    function automatic bit model_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef WR_ARB_ROUND_ROBIN_EN
            return !last_win;
`else
            return 1'b0;
`endif
        end
        return r1 && !r0;
    endfunction

    task automatic fill_words(input int mode);
        for (int i = 0; i < 8; i++) begin
            case (mode)
                1: begin
                    w0[i] = 32'hA0 + 32'(i); w1[i] = 32'hB0 + 32'(i);
                    m0[i] = 4'h0; m1[i] = 4'h0;
                end
                2: begin
                    w0[i] = $urandom; w1[i] = $urandom;
                    m0[i] = 4'b0101; m1[i] = 4'b0101;
                end
                default: begin
                    w0[i] = $urandom; w1[i] = $urandom;
                    m0[i] = 4'($urandom); m1[i] = 4'($urandom);
                end
            endcase
        end
        base0 = ack_cnt0;
        base1 = ack_cnt1;
    endtask

    task automatic push_burst(input bit w);
        beat_t b;
        for (int i = 0; i < BL; i++) begin
            b.w = w;
            b.d = w ? w1[i] : w0[i];
            b.m = w ? m1[i] : m0[i];
            sb.push_back(b);
        end
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_burst(input bit r0, input bit r1, input int dly, input int mode, input bit recov_ack);
        bit w;
        logic [1:0] g;
        fill_words(mode);
        w = model_winner(r0, r1);
        g = w ? 2'b10 : 2'b01;
        push_burst(w);
        req0 = r0;
        req1 = r1;
        @(negedge clk0);
        chk("grant", {gnt1, gnt0}, g);
        chk("wr_req_set", wr_req, 1'b1);
        chk("busy_cmd", busy, 1'b1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk0);
            chk("wr_req_hold", wr_req, 1'b1);
        end
        wr_ack = 1'b1;
        @(negedge clk0);
        wr_ack = 1'b0;
        chk("wr_req_clear", wr_req, 1'b0);
        chk("no_valid_first_data_cycle", data_valid, 1'b0);
        for (int i = 0; i < BL; i++) begin
            @(negedge clk0);
            chk("valid_run", data_valid, 1'b1);
            chk("grant_stable", {gnt1, gnt0}, g);
        end
        @(negedge clk0);
        chk("recov_valid", data_valid, 1'b0);
        chk("recov_busy", busy, 1'b1);
        chk("recov_gnt", {gnt1, gnt0}, 2'b00);
        chk("recov_dm", dm, 4'hF);
        chk("recov_ack", {ack1, ack0}, 2'b00);
        last_win = w;
        req0 = 1'b0;
        req1 = 1'b0;
        if (recov_ack) wr_ack = 1'b1;
        @(negedge clk0);
        wr_ack = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_dm", dm, 4'hF);
        chk("idle_datain", datain, 32'h0);
        @(negedge clk0);
        chk("idle_stays", {busy, wr_req, data_valid}, 3'b000);
    endtask

    task automatic chk_reset_values();
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_ack", {ack1, ack0}, 2'b00);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_datain", datain, 32'h0);
        chk("rst_dm", dm, 4'hF);
    endtask

    initial begin
        int r;
        reset  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        wr_ack = 1'b0;
        fill_words(0);
        repeat (2) @(negedge clk0);
        chk_reset_values();
        reset = 1'b1;
        @(negedge clk0);
        chk("post_reset_idle", busy, 1'b0);

        // Single host burst with counting words, wr_ack two cycles after wr_req.
        run_burst(1'b1, 1'b0, 2, 1, 1'b0);
        // Simultaneous requests, two bursts.
        run_burst(1'b1, 1'b1, 1, 0, 1'b0);
        run_burst(1'b1, 1'b1, 0, 0, 1'b0);
        // Byte mask pass-through; wr_ack pulsed in RECOV.
        run_burst(1'b0, 1'b1, 1, 2, 1'b1);

        // Requester drops in CMD, then wr_ack pulsed in IDLE.
        req1 = 1'b1;
        @(negedge clk0);
        chk("drop_grant", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        @(negedge clk0);
        chk("drop_gnt_clear", {gnt1, gnt0}, 2'b00);
        chk("drop_wr_req_clear", wr_req, 1'b0);
        chk("drop_idle", busy, 1'b0);
        wr_ack = 1'b1;
        @(negedge clk0);
        wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            chk("idle_ack_ignored", {busy, data_valid}, 2'b00);
        end

        // Reset on the second data word.
        fill_words(0);
        push_burst(1'b0);
        req0 = 1'b1;
        @(negedge clk0);
        chk("rst_test_grant", {gnt1, gnt0}, 2'b01);
        wr_ack = 1'b1;
        @(negedge clk0);
        wr_ack = 1'b0;
        @(negedge clk0);
        @(negedge clk0);
        chk("second_word_valid", data_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk_reset_values();
        sb.delete();
        last_win = 1'b1;
        req0 = 1'b0;
        @(negedge clk0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk0);
            chk("post_abort_quiet", {busy, data_valid}, 2'b00);
        end
        // Pointer must favour requester 0 again after reset.
        run_burst(1'b1, 1'b1, 1, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 16; n++) begin
            r = $urandom_range(1, 3);
            run_burst(r[0], r[1], $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_wr_arbiter.md
SDRAM_WR_ARBITER -- requirements
Module: sdram_wr_arbiter

Interface
REQ-001 SHALL have parameter data_size, default 32, host write data width.
REQ-002 SHALL have parameter dqm_size, default 4, byte-mask width (data_size/8).
REQ-003 SHALL have parameter burst_len, default 4, words per write burst (legal range 1..8).
REQ-004 SHALL have port clk0  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0, req1  in  1  host write request, held until burst done or abandoned.
REQ-007 SHALL have ports wdata0, wdata1  in  data_size  host write word.
REQ-008 SHALL have ports wdm0, wdm1  in  dqm_size  host byte mask (1 = masked).
REQ-009 SHALL have ports gnt0, gnt1  out  1  requester owns the write path.
REQ-010 SHALL have ports ack0, ack1  out  1  one-cycle pulse: current word consumed, present next.
REQ-011 SHALL have port wr_req  out  1  write command request to the command sequencer.
REQ-012 SHALL have port wr_ack  in  1  command sequencer issued WRITE; data phase starts.
REQ-013 SHALL have ports datain, dm, data_valid  out  data_size/dqm_size/1  to the data-in register.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, CMD, DATA, RECOV; all outputs registered.
REQ-016 In IDLE with any req high at edge N, SHALL latch winner, enter CMD, and drive gnt(winner)=1 and wr_req=1 from cycle N+1.
REQ-017 In CMD, SHALL hold wr_req until wr_ack is sampled high, then enter DATA and clear wr_req.
REQ-018 In CMD, if the winner drops req before wr_ack, SHALL return to IDLE and clear gnt and wr_req; if wr_ack and the req drop occur on the same edge, wr_ack wins.
REQ-019 In DATA, SHALL present wdata/wdm of the winner on datain/dm with data_valid=1 for exactly burst_len consecutive cycles, starting at edge M+1 where M is the wr_ack edge.
REQ-020 In DATA, SHALL pulse ack(winner) during each cycle a word is captured, and SHALL ignore req changes until the burst completes.
REQ-021 SHALL count words with a counter 0..burst_len-1 and enter RECOV after the last word, with no wrap-around and no extra word.
REQ-022 SHALL hold RECOV for one cycle with gnt=0, data_valid=0 and dm all ones, then enter IDLE.
REQ-023 Outside DATA, SHALL drive dm all ones and datain 0, and SHALL keep ack0, ack1 and data_valid low.
REQ-024 SHALL assert at most one gnt at a time, and gnt SHALL stay stable from CMD entry through the last DATA word.
REQ-025 SHALL ignore wr_ack outside CMD.

Reset
REQ-026 On reset low, SHALL asynchronously enter IDLE, clear the counter, and set the round-robin pointer to favour requester 0.
REQ-027 Reset values SHALL be: gnt0/1=0, ack0/1=0, wr_req=0, data_valid=0, busy=0, datain=0, dm all ones.
REQ-028 Reset mid-burst SHALL abandon the burst immediately; no further data_valid after reset release until a new grant.

Configuration
REQ-029 With WR_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not granted last SHALL win; the pointer SHALL update on every DATA completion.
REQ-030 Without WR_ARB_ROUND_ROBIN_EN: req0 SHALL always win ties (fixed priority), and no pointer register SHALL exist.

Structure
REQ-031 data_size, dqm_size, burst_len and the state encodings SHALL reside in the shared parameter include used by the SDRAM controller.
REQ-032 The winner selection SHALL be one sub-module, wr_arb_select (req0, req1, pointer -> winner); the FSM and counter SHALL stay in the top module.

Verification
REQ-033 req0 only, wr_ack two cycles after wr_req, burst_len=4, wdata0=0xA0..0xA3 -> four data_valid cycles with datain A0,A1,A2,A3, four ack0 pulses, busy low two cycles after the last word.
REQ-034 req0 and req1 asserted together for two bursts, round-robin enabled -> grants 0 then 1; with the macro undefined -> grants 0 then 0.
REQ-035 req1 dropped in CMD before wr_ack -> gnt1 and wr_req low the next cycle, no data_valid, state IDLE.
REQ-036 wdm1=4'b0101 during a burst -> dm=0101 on valid cycles, 1111 in RECOV and IDLE.
REQ-037 reset low on the second DATA word -> all outputs at reset values asynchronously; after release with no req, no further data_valid.
REQ-038 wr_ack pulsed in IDLE and RECOV -> no state change, no data_valid.
